// File: rtl/text_buf_arbiter.sv
// Arbiter/sequencer for the 256 x 8 text-overlay character buffer: display fetch,
// host write, host read and a fill-code clear engine share one single-port RAM.
module text_buf_arbiter #(
    parameter int unsigned        ADDR_W    = 8,
    parameter int unsigned        DATA_W    = 8,
    parameter logic [DATA_W-1:0]  FILL_CHAR = DATA_W'(8'h20)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_dvalid,
    output logic [DATA_W-1:0] disp_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_rvalid,
    output logic [DATA_W-1:0] rd_rdata,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic {S_IDLE, S_CLEAR} state_e;
    typedef enum logic [1:0] {TAG_NONE, TAG_DISP, TAG_HOST} tag_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
    logic                rr_q, rr_d;            // 1: read side favoured on a tie
    tag_e                tag0_q, tag0_d, tag1_q;
    logic                ram_en_q, ram_en_d, ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
    logic                disp_dvalid_q, rd_rvalid_q;
    logic [DATA_W-1:0]   disp_data_q, rd_rdata_q;
    logic                clr_busy_q, clr_done_q;

    logic gnt_clr, host_ok, gnt_wr, gnt_rd, clr_last;

    // Display always wins; clear owns the remaining slots while active; hosts share IDLE.
    assign gnt_clr  = (state_q == S_CLEAR) && !disp_req;
    assign host_ok  = (state_q == S_IDLE) && !disp_req;
    assign gnt_wr   = host_ok && wr_valid && (!rd_valid || !rr_q);
    assign gnt_rd   = host_ok && rd_valid && !gnt_wr;
    assign clr_last = gnt_clr && (clr_addr_q == {ADDR_W{1'b1}});

    assign wr_ready = gnt_wr && rst_n;
    assign rd_ready = gnt_rd && rst_n;

    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        rr_d        = rr_q;
        tag0_d      = TAG_NONE;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;

        if (disp_req) begin
            ram_en_d   = 1'b1;
            ram_addr_d = disp_addr;
            tag0_d     = TAG_DISP;
        end else if (gnt_clr) begin
            ram_en_d    = 1'b1;
            ram_we_d    = 1'b1;
            ram_addr_d  = clr_addr_q;
            ram_wdata_d = FILL_CHAR;
            clr_addr_d  = clr_addr_q + ADDR_W'(1);
        end else if (gnt_wr) begin
            ram_en_d    = 1'b1;
            ram_we_d    = 1'b1;
            ram_addr_d  = wr_addr;
            ram_wdata_d = wr_data;
            rr_d        = 1'b1;
        end else if (gnt_rd) begin
            ram_en_d   = 1'b1;
            ram_addr_d = rd_addr;
            tag0_d     = TAG_HOST;
            rr_d       = 1'b0;
        end

        unique case (state_q)
            S_IDLE:  if (clr_start) state_d = S_CLEAR;
            S_CLEAR: if (clr_last)  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            clr_addr_q    <= '0;
            rr_q          <= 1'b0;
            tag0_q        <= TAG_NONE;
            tag1_q        <= TAG_NONE;
            ram_en_q      <= 1'b0;
            ram_we_q      <= 1'b0;
            ram_addr_q    <= '0;
            ram_wdata_q   <= '0;
            disp_dvalid_q <= 1'b0;
            disp_data_q   <= '0;
            rd_rvalid_q   <= 1'b0;
            rd_rdata_q    <= '0;
            clr_busy_q    <= 1'b0;
            clr_done_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            clr_addr_q    <= clr_addr_d;
            rr_q          <= rr_d;
            tag0_q        <= tag0_d;
            tag1_q        <= tag0_q;
            ram_en_q      <= ram_en_d;
            ram_we_q      <= ram_we_d;
            ram_addr_q    <= ram_addr_d;
            ram_wdata_q   <= ram_wdata_d;
            clr_busy_q    <= (state_d == S_CLEAR);
            clr_done_q    <= clr_last;
            // Tag in stage 2 lines up with ram_rdata of the same fetch.
            disp_dvalid_q <= (tag1_q == TAG_DISP);
            rd_rvalid_q   <= (tag1_q == TAG_HOST);
            if (tag1_q == TAG_DISP) disp_data_q <= ram_rdata;
            if (tag1_q == TAG_HOST) rd_rdata_q  <= ram_rdata;
        end
    end

    assign ram_en      = ram_en_q;
    assign ram_we      = ram_we_q;
    assign ram_addr    = ram_addr_q;
    assign ram_wdata   = ram_wdata_q;
    assign disp_dvalid = disp_dvalid_q;
    assign disp_data   = disp_data_q;
    assign rd_rvalid   = rd_rvalid_q;
    assign rd_rdata    = rd_rdata_q;
    assign clr_busy    = clr_busy_q;
    assign clr_done    = clr_done_q;

endmodule

// File: tb/tb_text_buf_arbiter.sv
// Scoreboard bench for text_buf_arbiter: directed vectors push expected RAM ops and
// read returns; a negedge monitor pops and compares them against the DUT outputs.
module tb_text_buf_arbiter;

    typedef struct {
        int         cyc;
        logic       we;
        logic [7:0] addr;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       disp_req = 1'b0;
    logic [7:0] disp_addr = '0;
    logic       disp_dvalid;
    logic [7:0] disp_data;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [7:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       rd_valid = 1'b0;
    logic       rd_ready;
    logic [7:0] rd_addr = '0;
    logic       rd_rvalid;
    logic [7:0] rd_rdata;
    logic       clr_start = 1'b0;
    logic       clr_busy;
    logic       clr_done;
    logic       ram_en;
    logic       ram_we;
    logic [7:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata = '0;

    text_buf_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .disp_req(disp_req), .disp_addr(disp_addr),
        .disp_dvalid(disp_dvalid), .disp_data(disp_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata),
        .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    logic [7:0] mem    [256];
    logic [7:0] shadow [256];
    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]    = 8'(i * 7 + 3);
            shadow[i] = 8'(i * 7 + 3);
        end
    end

    // Synchronous single-port RAM, one-cycle read latency
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    int   exp_done_cyc = -1;
    logic exp_wr_rdy = 1'b0;
    logic exp_rd_rdy = 1'b0;
    logic exp_busy = 1'b0;
    logic [7:0] clr_exp = '0;
    exp_t ram_q[$];
    exp_t disp_q[$];
    exp_t rd_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    // One clock of stimulus; g is the hand-decided grant for this cycle (D/W/R/C/-).
    task automatic drive(input logic dq, input logic [7:0] da,
                         input logic wv, input logic [7:0] wa, input logic [7:0] wd,
                         input logic rv, input logic [7:0] ra,
                         input logic cs, input byte g);
        disp_req = dq; disp_addr = da;
        wr_valid = wv; wr_addr = wa; wr_data = wd;
        rd_valid = rv; rd_addr = ra;
        clr_start = cs;
        exp_wr_rdy = (g == "W");
        exp_rd_rdy = (g == "R");
        case (g)
            "D": begin
                ram_q.push_back(exp_t'{cyc + 1, 1'b0, da, 8'h00});
                disp_q.push_back(exp_t'{cyc + 3, 1'b0, da, shadow[da]});
            end
            "W": begin
                ram_q.push_back(exp_t'{cyc + 1, 1'b1, wa, wd});
                shadow[wa] = wd;
            end
            "R": begin
                ram_q.push_back(exp_t'{cyc + 1, 1'b0, ra, 8'h00});
                rd_q.push_back(exp_t'{cyc + 3, 1'b0, ra, shadow[ra]});
            end
            "C": begin
                ram_q.push_back(exp_t'{cyc + 1, 1'b1, clr_exp, 8'h20});
                shadow[clr_exp] = 8'h20;
                clr_exp++;
            end
            default: ;
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "-");
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        disp_req = 1'b0; clr_start = 1'b0;
        wr_valid = 1'b1; rd_valid = 1'b1;
        #1;
        ram_q.delete(); disp_q.delete(); rd_q.delete();
        clr_exp = '0; exp_busy = 1'b0; exp_done_cyc = -1;
        exp_wr_rdy = 1'b0; exp_rd_rdy = 1'b0;
        chk("rst_ram_outs", {ram_en, ram_we, ram_addr, ram_wdata}, 0);
        chk("rst_rd_outs", {disp_dvalid, disp_data, rd_rvalid, rd_rdata}, 0);
        chk("rst_ctl_outs", {clr_busy, clr_done, wr_ready, rd_ready}, 0);
        wr_valid = 1'b0; rd_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Clear with a display fetch every dper-th cycle (0 = none); stops after nstop clear writes.
    task automatic run_clear(input int dper, input int nstop);
        int k = 0;
        int n = 0;
        exp_busy = 1'b0;
        drive(1'b0, 8'h00, 1'b1, 8'h30, 8'h77, 1'b0, 8'h00, 1'b1, "W");
        exp_busy = 1'b1;
        while (n < nstop) begin
            if (dper != 0 && (k % dper) == dper - 1) begin
                drive(1'b1, k[7:0], 1'b1, 8'h55, 8'h66, 1'b1, 8'h30, (k == 50), "D");
            end else begin
                if (n == 255) exp_done_cyc = cyc + 1;
                drive(1'b0, 8'h00, 1'b1, 8'h55, 8'h66, 1'b1, 8'h30, (k == 50), "C");
                n++;
            end
            k++;
        end
        if (nstop == 256) begin
            exp_busy = 1'b0;
            drive(1'b0, 8'h00, 1'b1, 8'h55, 8'h66, 1'b1, 8'h30, 1'b0, "R");
            drive(1'b0, 8'h00, 1'b1, 8'h55, 8'h66, 1'b0, 8'h00, 1'b0, "W");
            idle(4);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            exp_t e;
            chk("wr_ready", wr_ready, exp_wr_rdy);
            chk("rd_ready", rd_ready, exp_rd_rdy);
            chk("clr_busy", clr_busy, exp_busy);
            if (clr_done || cyc == exp_done_cyc) chk("clr_done", clr_done, (cyc == exp_done_cyc));
            if (clr_done) done_cnt++;

            if (ram_q.size() > 0 && ram_q[0].cyc < cyc) begin
                chk("ram_op_missing_at", cyc, ram_q[0].cyc);
                void'(ram_q.pop_front());
            end
            if (ram_en) begin
                if (ram_q.size() == 0) chk("ram_op_unexpected", ram_en, 1'b0);
                else begin
                    e = ram_q.pop_front();
                    chk("ram_cycle", cyc, e.cyc);
                    chk("ram_we", ram_we, e.we);
                    chk("ram_addr", ram_addr, e.addr);
                    if (e.we) chk("ram_wdata", ram_wdata, e.data);
                end
            end

            if (disp_q.size() > 0 && disp_q[0].cyc < cyc) begin
                chk("disp_missing_at", cyc, disp_q[0].cyc);
                void'(disp_q.pop_front());
            end
            if (disp_dvalid) begin
                if (disp_q.size() == 0) chk("disp_unexpected", disp_dvalid, 1'b0);
                else begin
                    e = disp_q.pop_front();
                    chk("disp_cycle", cyc, e.cyc);
                    chk("disp_data", disp_data, e.data);
                end
            end

            if (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
                chk("rd_missing_at", cyc, rd_q[0].cyc);
                void'(rd_q.pop_front());
            end
            if (rd_rvalid) begin
                if (rd_q.size() == 0) chk("rd_unexpected", rd_rvalid, 1'b0);
                else begin
                    e = rd_q.pop_front();
                    chk("rd_cycle", cyc, e.cyc);
                    chk("rd_rdata", rd_rdata, e.data);
                end
            end
        end
    end

    initial begin
        #1;
        do_reset();

        // Idle after reset: nothing moves for 10 cycles
        for (int i = 0; i < 10; i++) begin
            idle(1);
            chk("idle_ram_en", ram_en, 1'b0);
            chk("idle_valids", {disp_dvalid, rd_rvalid, clr_busy, clr_done}, 0);
        end

        // Host write 0x41 -> 0x25, then read it back
        drive(1'b0, 8'h00, 1'b1, 8'h25, 8'h41, 1'b0, 8'h00, 1'b0, "W");
        drive(1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 8'h25, 1'b0, "R");
        idle(4);

        // Display hogs the port for 8 cycles; the held write goes on the first free slot
        for (int i = 0; i < 8; i++)
            drive(1'b1, 8'(i * 3), 1'b1, 8'h80, 8'h99, 1'b0, 8'h00, 1'b0, "D");
        drive(1'b0, 8'h00, 1'b1, 8'h80, 8'h99, 1'b0, 8'h00, 1'b0, "W");
        idle(4);

        // Round-robin from reset: W,R,W,R,W,R
        do_reset();
        for (int i = 0; i < 6; i++)
            drive(1'b0, 8'h00, 1'b1, 8'(8'h10 + i / 2), 8'(8'hA0 + i / 2),
                  1'b1, 8'(8'h10 + i / 2), 1'b0, (i % 2 == 0) ? "W" : "R");
        idle(4);

        // Full clear with display every 4th cycle
        done_cnt = 0;
        run_clear(4, 256);
        chk("clr_done_count", done_cnt, 1);

        // Reset with clr_addr at 100, then a fresh clear from address 0
        run_clear(0, 100);
        do_reset();
        chk("clr_busy_after_rst", clr_busy, 1'b0);
        run_clear(0, 256);
        chk("clr_done_count_2", done_cnt, 2);
        chk("shadow_match_0xff", mem[255], shadow[255]);

        chk("ram_q_left", ram_q.size(), 0);
        chk("disp_q_left", disp_q.size(), 0);
        chk("rd_q_left", rd_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/text_buf_arbiter.md
# text_buf_arbiter

Arbiter and sequencer for the single-port 256 x 8 character buffer behind the text overlay: 16 columns x 16 rows of 8-bit character codes, matching the 128 x 256 font area. Three agents share one RAM port with at most one operation per cycle: the display character fetch, a host write port, and a host read port from game logic. A built-in clear engine fills the buffer with a fill code. Sits between the game-logic/UART side and the draw_text pixel pipeline, in the 65 MHz VGA clock domain.

## Interface
- ADDR_W, 8, buffer address width (256 entries = CHAR_NUMBER)
- DATA_W, 8, character code width (CHAR_BIT_LENGTH)
- FILL_CHAR, 8'h20, code written by the clear engine
- clk  in  1  pixel clock; all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- disp_req  in  1  display fetch request, single-cycle strobe; never stalled
- disp_addr  in  ADDR_W  display fetch address
- disp_dvalid  out  1  display read data valid
- disp_data  out  DATA_W  display read data
- wr_valid / wr_ready  in / out  1  host write handshake
- wr_addr, wr_data  in  ADDR_W, DATA_W  host write payload
- rd_valid / rd_ready  in / out  1  host read-request handshake
- rd_addr  in  ADDR_W  host read address
- rd_rvalid  out  1  host read data valid
- rd_rdata  out  DATA_W  host read data
- clr_start  in  1  start-clear strobe
- clr_busy  out  1  clear in progress
- clr_done  out  1  one-cycle pulse at clear completion
- ram_en, ram_we  out  1  RAM strobes, registered
- ram_addr, ram_wdata  out  ADDR_W, DATA_W  RAM address and write data, registered
- ram_rdata  in  DATA_W  RAM read data, valid one cycle after ram_en with ram_we=0

## Operation
- FSM states: IDLE and CLEAR.
  - IDLE -> CLEAR on clr_start; a clr_start seen in CLEAR is ignored.
  - CLEAR -> IDLE after the write to address 255 is issued.
- Per-cycle grant priority:
  1. Display: disp_req always wins, in both states.
  2. CLEAR state: the clear write at clr_addr, then clr_addr+1. Host ports are stalled (wr_ready = rd_ready = 0).
  3. IDLE state: host write or host read, round-robin.
- Round-robin:
  - 1-bit pointer toggles after every host grant.
  - When both wr_valid and rd_valid are high, the side not granted last wins.
  - A lone valid wins immediately.
  - Reset pointer favours write.
- Ready signals:
  - wr_ready and rd_ready are combinational and may depend on valid.
  - Each is high only in the cycle that side is granted.
  - A transfer occurs on valid & ready.
  - Requesters must hold valid and payload stable until the transfer.
- Read-return tagging: a 2-stage tag pipeline (none/disp/host) steers ram_rdata to exactly one of disp_data/disp_dvalid or rd_rdata/rd_rvalid. Data outputs are registered.
- Clear counter is ADDR_W wide and increments only on cycles where the clear write is granted. Display preemption stretches a clear; it never skips an address.
- clr_done pulses in the cycle after the final clear write is issued. clr_busy falls in that same cycle.

## Timing
- Grant at cycle N -> ram_* valid at N+1 -> ram_rdata at N+2 -> disp_dvalid/rd_rvalid and data at N+3.
- Read latency from request to data is a fixed 3 cycles.
- Write is visible in RAM at the N+1 edge.
- Throughput: one RAM op per cycle. A host read and a host write may be granted on back-to-back cycles.
- Clear with no display traffic: 256 cycles. clr_busy is high from cycle N+1 after clr_start through the final issue cycle.
- A clr_start arriving in IDLE does not block a host grant in that same cycle. CLEAR begins on the next cycle.
- A host transfer accepted before CLEAR still completes normally, including its read return.
- Reset, async assert, mid-operation:
  - All outputs go to 0: ram_en, ram_we, ram_addr, ram_wdata, disp_dvalid, disp_data, rd_rvalid, rd_rdata, clr_busy, clr_done.
  - wr_ready = rd_ready = 0.
  - State returns to IDLE, clr_addr = 0, tag pipeline cleared, RR pointer favours write.
  - In-flight reads are dropped. A partial clear is abandoned.

## Test plan
- Reset idle: rst_n low, then released with no requests -> all outputs 0, ready low, ram_en 0 for 10 cycles.
- Host write then read:
  - Stimulus: write 0x41 to 0x25, then read 0x25.
  - Required: ram_we=1, addr 0x25 one cycle after the write transfer; rd_rvalid with rd_rdata=0x41 exactly 3 cycles after the read transfer.
- Display priority: disp_req every cycle for 8 cycles with wr_valid held -> wr_ready stays 0. The write completes on the first free cycle; every disp_dvalid arrives at +3.
- Round-robin: wr_valid and rd_valid held together for 6 cycles -> grants alternate W,R,W,R,W,R starting with W after reset.
- Clear:
  - Stimulus: clr_start, with disp_req every 4th cycle.
  - Required: all 256 addresses written with 0x20 in order, none skipped; host ready stays low; clr_done is a single pulse; total length = 256 + display grants.
- Reset mid-clear: rst_n asserted at clr_addr=100 -> clr_busy=0 immediately. After release, a new clr_start restarts from address 0.
